// File: rtl/seq_div_pkg.sv
// Shared constants for the sequential restoring mantissa divider.
// Holds default widths, the counter-width helper and the FSM state encoding.
package seq_div_pkg;

  localparam int unsigned WIDTH_DEF = 24;
  localparam int unsigned QBITS_DEF = 26;

  // Width of a counter that must reach n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(QBITS_DEF);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_ITER = 2'd3;

endpackage

// File: rtl/seq_div_cu.sv
// Control unit of the divider: Idle/Init/Load/Iter FSM, iteration counter and
// datapath strobes. Optional macro SEQDIV_ABORT_EN lets a start request
// during Iter restart the operation.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       level start request; the operation begins on its release
//   special_i     operands are divide-by-zero or overflow (finish in Load)
//   clear_c_o, load_c_o, iter_c_o, last_c_o   datapath strobes
//   done_o        registered, high only in Idle
module seq_div_cu
  import seq_div_pkg::*;
#(
  parameter int unsigned QBITS = QBITS_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic special_i,
  output logic clear_c_o,
  output logic load_c_o,
  output logic iter_c_o,
  output logic last_c_o,
  output logic done_o
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             last_c;

  assign last_c = (cnt_q == CNT_W'(QBITS - 1));

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clear_c_o = 1'b0;
    load_c_o  = 1'b0;
    iter_c_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Clearing on entry keeps the quotient at zero for the whole Init stay.
        if (start_i) begin
          state_d   = ST_INIT;
          clear_c_o = 1'b1;
          cnt_d     = '0;
        end
      end
      ST_INIT: begin
        clear_c_o = 1'b1;
        cnt_d     = '0;
        if (!start_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_c_o = 1'b1;
        state_d  = special_i ? ST_IDLE : ST_ITER;
      end
      ST_ITER: begin
        iter_c_o = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_c) state_d = ST_IDLE;
`ifdef SEQDIV_ABORT_EN
        if (start_i) begin
          state_d   = ST_INIT;
          iter_c_o  = 1'b0;
          clear_c_o = 1'b1;
          cnt_d     = '0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign last_c_o = last_c;
  assign done_o   = done_q;

endmodule

// File: rtl/seq_div_dp.sv
// Datapath of the divider: remainder/divisor/quotient registers, the
// (WIDTH+1)-bit subtractor and the divide-by-zero / overflow detection.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a_i, b_i            dividend / divisor mantissas (used only in Load)
//   clear_i             clear quotient, remainder and flags
//   load_i, iter_i      Load / Iter strobes from the control unit
//   last_i              current iteration is the final one (no shift)
//   special_c_o         operands in a_i/b_i are a special case
//   quotient_o, remainder_o, sticky_o, div_by_zero_o, overflow_o  results
module seq_div_dp
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned QBITS = QBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             iter_i,
  input  logic             last_i,
  output logic             special_c_o,
  output logic [QBITS-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             sticky_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);

  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [QBITS-1:0] q_q, q_d;
  logic             sticky_q, sticky_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             b_zero_c;
  logic             ovf_c;
  logic             ge_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH:0]   sel_c;

  // Special-case detection on the live operands; A >= 2*B compared in WIDTH+1 bits.
  assign b_zero_c    = (b_i == '0);
  assign ovf_c       = ({1'b0, a_i} >= {b_i, 1'b0});
  assign special_c_o = b_zero_c | ovf_c;

  // One restoring step: subtract when the partial remainder covers the divisor.
  assign ge_c   = (r_q >= {1'b0, b_q});
  assign diff_c = r_q - {1'b0, b_q};
  assign sel_c  = ge_c ? diff_c : r_q;

  // Next-state logic for all datapath registers.
  always_comb begin
    r_d   = r_q;
    b_d   = b_q;
    q_d   = q_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      r_d   = '0;
      q_d   = '0;
      dbz_d = 1'b0;
      ovf_d = 1'b0;
    end else if (load_i) begin
      b_d = b_i;
      if (b_zero_c) begin
        dbz_d = 1'b1;
        q_d   = '1;
        r_d   = '0;
      end else if (ovf_c) begin
        ovf_d = 1'b1;
        q_d   = '1;
        r_d   = '0;
      end else begin
        r_d = {1'b0, a_i};
      end
    end else if (iter_i) begin
      q_d = {q_q[QBITS-2:0], ge_c};
      // The final step keeps the true remainder instead of pre-shifting.
      r_d = last_i ? sel_c : {sel_c[WIDTH-1:0], 1'b0};
    end
    sticky_d = |r_d[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      r_q      <= r_d;
      b_q      <= b_d;
      q_q      <= q_d;
      sticky_q <= sticky_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign quotient_o    = q_q;
  assign remainder_o   = r_q[WIDTH-1:0];
  assign sticky_o      = sticky_q;
  assign div_by_zero_o = dbz_q;
  assign overflow_o    = ovf_q;

endmodule

// File: rtl/seq_div.sv
// Sequential restoring mantissa divider, one quotient bit per clock.
// quotient = floor((A << (QBITS-1)) / B), remainder = the matching residue.
// Optional macro SEQDIV_ABORT_EN: startDiv during iteration restarts.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   startDiv     level start request; operation begins on its release
//   A, B         dividend / divisor mantissas, sampled in Load
//   quotient, remainder, sticky, divByZero, overflow   results
//   doneDiv      high only in Idle; results valid while high
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned QBITS = QBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startDiv,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [QBITS-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             sticky,
  output logic             divByZero,
  output logic             overflow,
  output logic             doneDiv
);

  localparam int unsigned CNT_W = cnt_width(QBITS);

  logic clear_c, load_c, iter_c, last_c, special_c;

  seq_div_cu #(
    .QBITS (QBITS),
    .CNT_W (CNT_W)
  ) u_cu (
    .clk       (clk),
    .rst       (rst),
    .start_i   (startDiv),
    .special_i (special_c),
    .clear_c_o (clear_c),
    .load_c_o  (load_c),
    .iter_c_o  (iter_c),
    .last_c_o  (last_c),
    .done_o    (doneDiv)
  );

  seq_div_dp #(
    .WIDTH (WIDTH),
    .QBITS (QBITS)
  ) u_dp (
    .clk           (clk),
    .rst           (rst),
    .a_i           (A),
    .b_i           (B),
    .clear_i       (clear_c),
    .load_i        (load_c),
    .iter_i        (iter_c),
    .last_i        (last_c),
    .special_c_o   (special_c),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .sticky_o      (sticky),
    .div_by_zero_o (divByZero),
    .overflow_o    (overflow)
  );

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: the driver pushes reference-model results,
// a monitor pops one entry on every rising doneDiv and compares it.
module tb_seq_div;

  localparam int unsigned W  = 24;
  localparam int unsigned QB = 26;

  logic          clk = 1'b0;
  logic          rst;
  logic          startDiv;
  logic [W-1:0]  A, B;
  logic [QB-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          sticky, divByZero, overflow, doneDiv;

  seq_div dut (
    .clk       (clk),
    .rst       (rst),
    .startDiv  (startDiv),
    .A         (A),
    .B         (B),
    .quotient  (quotient),
    .remainder (remainder),
    .sticky    (sticky),
    .divByZero (divByZero),
    .overflow  (overflow),
    .doneDiv   (doneDiv)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a negedge it is the index of the next edge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [QB-1:0] q;
    logic [W-1:0]  r;
    logic          s;
    logic          z;
    logic          o;
    int unsigned   edge_n;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer division of A*2^(QB-1) by B; rel = first edge that sees start low.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int unsigned rel);
    exp_t x;
    longint unsigned av, bv, num, qq;
    av = a;
    bv = b;
    x.z = 1'b0;
    x.o = 1'b0;
    if (bv == 0) begin
      x.z = 1'b1; x.q = '1; x.r = '0;
      x.edge_n = rel + 1;
    end else if (av >= 2 * bv) begin
      x.o = 1'b1; x.q = '1; x.r = '0;
      x.edge_n = rel + 1;
    end else begin
      num = av << (QB - 1);
      qq  = num / bv;
      x.q = QB'(qq);
      x.r = W'(num - qq * bv);
      x.edge_n = rel + 1 + QB;
    end
    x.s = (x.r != 0);
    return x;
  endfunction

  function automatic exp_t reset_exp(input int unsigned e);
    exp_t x;
    x.q = '0; x.r = '0; x.s = 1'b0; x.z = 1'b0; x.o = 1'b0; x.edge_n = e;
    return x;
  endfunction

  // Monitor: compare on each rising doneDiv.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b0 && doneDiv === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got=1 exp=0 (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          check("done_edge", 64'(cyc - 1), 64'(e.edge_n));
          check("quotient", 64'(quotient), 64'(e.q));
          check("remainder", 64'(remainder), 64'(e.r));
          check("sticky", 64'(sticky), 64'(e.s));
          check("divByZero", 64'(divByZero), 64'(e.z));
          check("overflow", 64'(overflow), 64'(e.o));
        end
      end
      prev = doneDiv;
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  // Hold start for 'hold' edges, release, then scramble operands after Load.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, output int unsigned rel);
    @(negedge clk);
    A = a;
    B = b;
    startDiv = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("init_quotient", 64'(quotient), 64'd0);
      check("init_done", 64'(doneDiv), 64'd0);
    end
    startDiv = 1'b0;
    rel = cyc;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int unsigned rel;
    start_op(a, b, hold, rel);
    sbq.push_back(model(a, b, rel));
    repeat (2) @(negedge clk);
    A = W'($urandom);
    B = W'($urandom);
    wait_drain();
  endtask

  // Disturb an operation at iteration 10 with reset (mode 0) or a new start (mode 1).
  task automatic run_mid(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] na, input logic [W-1:0] nb, input int mode);
    int unsigned rel;
    start_op(a, b, 1, rel);
    if (mode == 0) begin
      repeat (11) @(negedge clk);
      rst = 1'b1;
      sbq.push_back(reset_exp(cyc));
      @(negedge clk);
      rst = 1'b0;
    end else begin
`ifndef SEQDIV_ABORT_EN
      sbq.push_back(model(a, b, rel));
`endif
      repeat (11) @(negedge clk);
      A = na;
      B = nb;
      startDiv = 1'b1;
      @(negedge clk);
      startDiv = 1'b0;
`ifdef SEQDIV_ABORT_EN
      sbq.push_back(model(na, nb, cyc));
`endif
      repeat (2) @(negedge clk);
      A = W'($urandom);
      B = W'($urandom);
    end
    wait_drain();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int sel;
    rst = 1'b1;
    startDiv = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(doneDiv), 64'd1);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_sticky", 64'(sticky), 64'd0);
    check("rst_divByZero", 64'(divByZero), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(24'h800000, 24'h800000, 1);
    check("const_q_1_0", 64'(quotient), 64'h2000000);
    run_op(24'hC00000, 24'h800000, 1);
    check("const_q_1_5", 64'(quotient), 64'h3000000);
    run_op(24'h800000, 24'hC00000, 1);
    check("const_q_2_3", 64'(quotient), 64'h1555555);
    check("const_r_2_3", 64'(remainder), 64'h400000);
    run_op(24'hFFFFFF, 24'h800000, 1);
    check("const_q_max", 64'(quotient), 64'h3FFFFFC);
    run_op(24'h123456, 24'h000000, 1);
    check("const_q_dbz", 64'(quotient), 64'h3FFFFFF);
    run_op(24'h800000, 24'h400000, 1);
    check("const_ovf", 64'(overflow), 64'd1);
    run_op(24'hABCDEF, 24'hC00001, 5);
    run_op(24'hFFFFFF, 24'hFFFFFF, 2);
    run_op(24'h800000, 24'hFFFFFF, 1);

    run_mid(24'hD00000, 24'h900000, 24'h0, 24'h0, 0);
    run_op(24'h9ABCDE, 24'hF12345, 1);
    run_mid(24'hE00000, 24'hA00000, 24'h812345, 24'hB6789A, 1);
    run_op(24'h800001, 24'h800003, 1);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom) | 24'h800000;
      if (($urandom & 3) == 0) ra = W'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      rb = '0;
      else if (sel == 1) rb = ra >> 1;
      else if (sel == 2) rb = W'($urandom);
      else               rb = W'($urandom) | 24'h800000;
      run_op(ra, rb, $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
